sfp_send_scheduler: RTL and testbench

- Parametrised multi-channel packet-send scheduler, driving the per-MAC send_packet control ports (cmd_send, start_ram_addr) of the platform system design.
- Generalises the fixed two-channel, hard-coded-period send counter into NUM_CH channels, each with a runtime period, phase offset, start address and enable.
- Gates on link readiness (mac_inited && rx_ready) and honours a per-channel busy handshake from the packet sender.

---
 rtl/sfp_send_scheduler.sv | 126 ++++++++++++
 tb/tb_sfp_send_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_send_scheduler.sv
// Multi-channel periodic send scheduler driving per-MAC cmd_send / start_ram_addr ports.
// Optional SEND_SCHED_STATS_EN adds saturating per-channel sent/skip counters.
module sfp_send_scheduler #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 32,
  parameter int ADDR_W    = 25,
  parameter int PULSE_LEN = 3
) (
  input  logic                     clk_50_pll,
  input  logic                     main_reset,
  input  logic                     mac_inited,
  input  logic                     rx_ready,
  input  logic [CNT_W-1:0]         period_i,
  input  logic [NUM_CH*CNT_W-1:0]  ch_offset_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  input  logic [NUM_CH-1:0]        ch_en_i,
  input  logic [NUM_CH-1:0]        ch_busy_i,
  output logic [NUM_CH-1:0]        cmd_send_o,
  output logic [NUM_CH*ADDR_W-1:0] start_ram_addr_o,
  output logic                     running_o
`ifdef SEND_SCHED_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]     sent_cnt_o,
  output logic [NUM_CH*16-1:0]     skip_cnt_o
`endif
);

  localparam int               PW      = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] MIN_PER = CNT_W'(PULSE_LEN + 1);
  localparam logic [PW-1:0]    PLEN    = PW'(PULSE_LEN);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic [CNT_W-1:0]   per_eff;
  logic [CNT_W-1:0]   per_clamped;
  logic               link_ok;
  logic [NUM_CH-1:0]  trig;
  logic [PW-1:0]      pulse_cnt [NUM_CH];

  assign link_ok     = mac_inited & rx_ready;
  // Clamping guarantees a pulse always ends before its channel can trigger again.
  assign per_clamped = (period_i < MIN_PER) ? MIN_PER : period_i;

  always_comb begin
    trig = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      trig[k] = (state == RUN) && link_ok && ch_en_i[k] &&
                (counter == ch_offset_i[k*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge clk_50_pll or posedge main_reset) begin
    if (main_reset) begin
      state            <= IDLE;
      counter          <= '0;
      per_eff          <= MIN_PER;
      cmd_send_o       <= '0;
      start_ram_addr_o <= '0;
      running_o        <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) pulse_cnt[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (link_ok) begin
            state     <= RUN;
            counter   <= '0;
            per_eff   <= per_clamped;
            running_o <= 1'b1;
          end
        end
        RUN: begin
          if (!link_ok) begin
            state      <= IDLE;
            counter    <= '0;
            running_o  <= 1'b0;
            cmd_send_o <= '0;
            for (int k = 0; k < NUM_CH; k++) pulse_cnt[k] <= '0;
          end else begin
            // Period changes are only picked up at the frame boundary.
            if (counter == per_eff - CNT_W'(1)) begin
              counter <= '0;
              per_eff <= per_clamped;
            end else begin
              counter <= counter + CNT_W'(1);
            end
            for (int k = 0; k < NUM_CH; k++) begin
              if (trig[k] && !ch_busy_i[k]) begin
                pulse_cnt[k]                          <= PLEN;
                cmd_send_o[k]                         <= 1'b1;
                start_ram_addr_o[k*ADDR_W +: ADDR_W]  <= ch_addr_i[k*ADDR_W +: ADDR_W];
              end else if (pulse_cnt[k] != '0) begin
                pulse_cnt[k]  <= pulse_cnt[k] - PW'(1);
                cmd_send_o[k] <= (pulse_cnt[k] > PW'(1));
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEND_SCHED_STATS_EN
  // Statistics survive link drops; only main_reset clears them.
  always_ff @(posedge clk_50_pll or posedge main_reset) begin
    if (main_reset) begin
      sent_cnt_o <= '0;
      skip_cnt_o <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (trig[k]) begin
          if (ch_busy_i[k]) begin
            if (skip_cnt_o[k*16 +: 16] != 16'hFFFF)
              skip_cnt_o[k*16 +: 16] <= skip_cnt_o[k*16 +: 16] + 16'd1;
          end else if (sent_cnt_o[k*16 +: 16] != 16'hFFFF) begin
            sent_cnt_o[k*16 +: 16] <= sent_cnt_o[k*16 +: 16] + 16'd1;
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sfp_send_scheduler.sv
// Bench for sfp_send_scheduler: directed scenarios plus randomized traffic against a time-based model.
module tb_sfp_send_scheduler;

  localparam int NUM_CH    = 2;
  localparam int CNT_W     = 32;
  localparam int ADDR_W    = 25;
  localparam int PULSE_LEN = 3;

  logic                     clk_50_pll = 1'b0;
  logic                     main_reset;
  logic                     mac_inited;
  logic                     rx_ready;
  logic [CNT_W-1:0]         period_i;
  logic [NUM_CH*CNT_W-1:0]  ch_offset_i;
  logic [NUM_CH*ADDR_W-1:0] ch_addr_i;
  logic [NUM_CH-1:0]        ch_en_i;
  logic [NUM_CH-1:0]        ch_busy_i;
  logic [NUM_CH-1:0]        cmd_send_o;
  logic [NUM_CH*ADDR_W-1:0] start_ram_addr_o;
  logic                     running_o;
`ifdef SEND_SCHED_STATS_EN
  logic [NUM_CH*16-1:0]     sent_cnt_o;
  logic [NUM_CH*16-1:0]     skip_cnt_o;
`endif

  sfp_send_scheduler #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .PULSE_LEN(PULSE_LEN)
  ) dut (
    .clk_50_pll(clk_50_pll),
    .main_reset(main_reset),
    .mac_inited(mac_inited),
    .rx_ready(rx_ready),
    .period_i(period_i),
    .ch_offset_i(ch_offset_i),
    .ch_addr_i(ch_addr_i),
    .ch_en_i(ch_en_i),
    .ch_busy_i(ch_busy_i),
    .cmd_send_o(cmd_send_o),
    .start_ram_addr_o(start_ram_addr_o),
    .running_o(running_o)
`ifdef SEND_SCHED_STATS_EN
    ,
    .sent_cnt_o(sent_cnt_o),
    .skip_cnt_o(skip_cnt_o)
`endif
  );

  always #5 clk_50_pll = ~clk_50_pll;

  int total = 0;
  int bad   = 0;

  // Model: absolute cycle numbers for frame starts and pulse starts.
  longint           cyc = 0;
  bit               m_run;
  longint           m_frame_start;
  longint           m_per;
  longint           m_start [NUM_CH];
  logic [ADDR_W-1:0] m_addr [NUM_CH];
  int               m_sent [NUM_CH];
  int               m_skip [NUM_CH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic longint clamp_per(input longint p);
    return (p < PULSE_LEN + 1) ? longint'(PULSE_LEN + 1) : p;
  endfunction

  function automatic bit exp_cmd(input int k);
    return (cyc >= m_start[k]) && (cyc < m_start[k] + PULSE_LEN);
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_frame_start = 0;
    m_per = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_start[k] = -1000;
      m_addr[k]  = '0;
      m_sent[k]  = 0;
      m_skip[k]  = 0;
    end
  endtask

  task automatic check_outputs();
    logic [NUM_CH-1:0]        ec;
    logic [NUM_CH*ADDR_W-1:0] ea;
`ifdef SEND_SCHED_STATS_EN
    logic [NUM_CH*16-1:0]     es;
    logic [NUM_CH*16-1:0]     ek;
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      ec[k] = exp_cmd(k);
      ea[k*ADDR_W +: ADDR_W] = m_addr[k];
`ifdef SEND_SCHED_STATS_EN
      es[k*16 +: 16] = 16'(m_sent[k]);
      ek[k*16 +: 16] = 16'(m_skip[k]);
`endif
    end
    chk("cmd_send", cmd_send_o, ec);
    chk("running", running_o, m_run);
    chk("start_addr", start_ram_addr_o, ea);
`ifdef SEND_SCHED_STATS_EN
    chk("sent_cnt", sent_cnt_o, es);
    chk("skip_cnt", skip_cnt_o, ek);
`endif
  endtask

  // Evaluate the current cycle's inputs in the model, clock once, then compare.
  task automatic tick();
    bit     link;
    longint pos;
    link = mac_inited && rx_ready;
    if (!m_run) begin
      if (link) begin
        m_run = 1'b1;
        m_frame_start = cyc + 1;
        m_per = clamp_per(longint'(period_i));
      end
    end else if (!link) begin
      m_run = 1'b0;
      for (int k = 0; k < NUM_CH; k++) m_start[k] = -1000;
    end else begin
      pos = cyc - m_frame_start;
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_en_i[k] && pos == longint'(ch_offset_i[k*CNT_W +: CNT_W])) begin
          if (ch_busy_i[k]) begin
            if (m_skip[k] < 65535) m_skip[k]++;
          end else begin
            m_start[k] = cyc + 1;
            m_addr[k]  = ch_addr_i[k*ADDR_W +: ADDR_W];
            if (m_sent[k] < 65535) m_sent[k]++;
          end
        end
      end
      if (pos == m_per - 1) begin
        m_frame_start = cyc + 1;
        m_per = clamp_per(longint'(period_i));
      end
    end
    @(posedge clk_50_pll);
    cyc++;
    #1;
    check_outputs();
  endtask

  // Count cycles until the next rising edge on cmd_send_o[0].
  task automatic wait_rise(input string tag, input int bound, input int exp_n);
    int   n;
    bit   found;
    logic prev;
    n = 0;
    found = 1'b0;
    while (!found && n < bound) begin
      prev = cmd_send_o[0];
      tick();
      n++;
      if (!prev && cmd_send_o[0]) found = 1'b1;
    end
    chk({tag, "_seen"}, found, 1);
    if (exp_n >= 0) chk(tag, n, exp_n);
  endtask

  task automatic async_reset();
    #2;
    main_reset = 1'b1;
    #1;
    model_reset();
    chk("areset_cmd", cmd_send_o, 0);
    chk("areset_running", running_o, 0);
    chk("areset_addr", start_ram_addr_o, 0);
`ifdef SEND_SCHED_STATS_EN
    chk("areset_sent", sent_cnt_o, 0);
    chk("areset_skip", skip_cnt_o, 0);
`endif
    @(posedge clk_50_pll);
    cyc++;
    #4;
    main_reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int per;
    main_reset  = 1'b1;
    mac_inited  = 1'b0;
    rx_ready    = 1'b0;
    period_i    = '0;
    ch_offset_i = '0;
    ch_addr_i   = '0;
    ch_en_i     = '0;
    ch_busy_i   = '0;
    model_reset();
    repeat (2) begin
      @(posedge clk_50_pll);
      cyc++;
    end
    #1;
    chk("reset_cmd", cmd_send_o, 0);
    chk("reset_running", running_o, 0);
    chk("reset_addr", start_ram_addr_o, 0);
    #3;
    main_reset = 1'b0;

    // Two channels at 0xFF / 0x1FF, period 0x20A.
    period_i = 32'h20A;
    ch_offset_i[0 +: CNT_W]     = 32'hFF;
    ch_offset_i[CNT_W +: CNT_W] = 32'h1FF;
    ch_addr_i[0 +: ADDR_W]      = 25'd1;
    ch_addr_i[ADDR_W +: ADDR_W] = 25'd1;
    ch_en_i    = 2'b11;
    mac_inited = 1'b1;
    rx_ready   = 1'b1;
    tick();
    chk("running_after_up", running_o, 1);
    wait_rise("first_rise_ch0", 2000, 32'h100);
    wait_rise("frame_gap_ch0", 2000, 32'h20A);
    repeat (32'h20A) tick();

    // Asynchronous reset in the middle of a ch0 pulse.
    n = 0;
    while (!exp_cmd(0) && n < 2000) begin
      tick();
      n++;
    end
    chk("pulse_before_reset", cmd_send_o[0], 1);
    tick();
    async_reset();

    // Busy channel 1 at its trigger point: skip, address untouched.
    ch_busy_i = 2'b10;
    repeat (32'h205) tick();
    chk("skip_addr1", start_ram_addr_o[ADDR_W +: ADDR_W], 0);
    chk("sent_addr0", start_ram_addr_o[0 +: ADDR_W], 1);
`ifdef SEND_SCHED_STATS_EN
    chk("skip_cnt1", skip_cnt_o[16 +: 16], 1);
    chk("sent_cnt1", sent_cnt_o[16 +: 16], 0);
    chk("sent_cnt0", sent_cnt_o[0 +: 16], 1);
`endif
    ch_busy_i = 2'b00;

    // Link drop during the second cycle of a ch0 pulse, then recovery.
    wait_rise("pre_drop_rise", 2000, -1);
    tick();
    rx_ready = 1'b0;
    tick();
    chk("drop_cmd0", cmd_send_o[0], 0);
    chk("drop_running", running_o, 0);
    repeat (5) tick();
    rx_ready = 1'b1;
    wait_rise("relink_rise", 2000, 32'h101);

    // Period 1 clamps to PULSE_LEN+1; offset 5 never fires.
    mac_inited = 1'b0;
    tick();
    period_i = 32'd1;
    ch_offset_i[0 +: CNT_W]     = 32'd0;
    ch_offset_i[CNT_W +: CNT_W] = 32'd5;
    mac_inited = 1'b1;
    wait_rise("short_first", 100, 2);
    wait_rise("short_gap", 100, 4);
    repeat (40) tick();

    // Period change mid-frame takes effect only after the current frame.
    mac_inited = 1'b0;
    tick();
    period_i = 32'h20A;
    ch_offset_i[CNT_W +: CNT_W] = 32'h50;
    mac_inited = 1'b1;
    wait_rise("chg_first", 100, 2);
    repeat (32'h100) tick();
    period_i = 32'h100;
    wait_rise("chg_old_frame", 2000, 32'h10A);
    wait_rise("chg_new_frame", 2000, 32'h100);

    // Randomized traffic: periods, offsets, enables, busy, addresses, link drops.
    for (int s = 0; s < 12; s++) begin
      per = $urandom_range(0, 200);
      period_i = CNT_W'(per);
      for (int k = 0; k < NUM_CH; k++) begin
        ch_offset_i[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, per + 10));
        ch_addr_i[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      end
      ch_en_i = NUM_CH'($urandom);
      mac_inited = 1'b1;
      rx_ready   = 1'b1;
      for (int i = 0; i < 400; i++) begin
        ch_busy_i = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
        if ($urandom_range(0, 99) == 0) ch_en_i = NUM_CH'($urandom);
        if ($urandom_range(0, 9) == 0)
          ch_addr_i[$urandom_range(0, NUM_CH-1)*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        if (i == 200) period_i = CNT_W'($urandom_range(0, 200));
        if (i >= 390 && (s % 2) == 0) rx_ready = 1'b0;
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
